// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: instruction register, IF/IW/ID/EX/ST/LD/RDW/WB sequencing and memory handshakes.
// Optional performance counters are built only when CTRL_PERF_CNT_EN is defined.
module mips_mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,
  input  logic        Zero,
  output logic [2:0]  ALUop,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        ALUOutWrite,
  output logic        RF_wen,
  output logic [4:0]  RF_waddr,
  output logic        MemtoReg,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic        Mem_Req_Ready,
  input  logic        Read_data_Valid,
  output logic [31:0] IR,
  output logic [31:0] Cycle_cnt,
  output logic [31:0] Inst_cnt
);

  typedef enum logic [2:0] {
    S_IF, S_IW, S_ID, S_EX, S_ST, S_LD, S_RDW, S_WB
  } state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_LUI  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  state_t      state;
  state_t      next_state;
  logic [31:0] ir;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       r_type;
  logic       is_addu, is_subu, is_and, is_or, is_slt, is_sltu, is_sll, is_jr;
  logic       is_addiu, is_slti, is_sltiu, is_lui, is_lw, is_sw, is_beq, is_bne, is_j;
  logic       known;

  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign r_type   = (opcode == 6'h00);
  assign is_addu  = r_type && (funct == 6'h21);
  assign is_subu  = r_type && (funct == 6'h23);
  assign is_and   = r_type && (funct == 6'h24);
  assign is_or    = r_type && (funct == 6'h25);
  assign is_slt   = r_type && (funct == 6'h2a);
  assign is_sltu  = r_type && (funct == 6'h2b);
  assign is_sll   = r_type && (funct == 6'h00);
  assign is_jr    = r_type && (funct == 6'h08);
  assign is_addiu = (opcode == 6'h09);
  assign is_slti  = (opcode == 6'h0a);
  assign is_sltiu = (opcode == 6'h0b);
  assign is_lui   = (opcode == 6'h0f);
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2b);
  assign is_beq   = (opcode == 6'h04);
  assign is_bne   = (opcode == 6'h05);
  assign is_j     = (opcode == 6'h02);

  assign known = is_addu | is_subu | is_and | is_or | is_slt | is_sltu | is_sll | is_jr |
                 is_addiu | is_slti | is_sltiu | is_lui | is_lw | is_sw |
                 is_beq | is_bne | is_j;

  always_comb begin
    next_state = state;
    case (state)
      S_IF:  if (Inst_Req_Ready) next_state = S_IW;
      S_IW:  if (Inst_Valid) next_state = S_ID;
      S_ID:  next_state = known ? S_EX : S_IF;
      S_EX: begin
        if (is_lw)                              next_state = S_LD;
        else if (is_sw)                         next_state = S_ST;
        else if (is_beq | is_bne | is_j | is_jr) next_state = S_IF;
        else                                    next_state = S_WB;
      end
      S_ST:  if (Mem_Req_Ready) next_state = S_IF;
      S_LD:  if (Mem_Req_Ready) next_state = S_RDW;
      S_RDW: if (Read_data_Valid) next_state = S_IF;
      S_WB:  next_state = S_IF;
      default: next_state = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IF;
      ir    <= 32'd0;
    end else begin
      state <= next_state;
      if (state == S_IW && Inst_Valid) ir <= Instruction;
    end
  end

  // Every control output is held low while rst is high, so an aborted instruction writes nothing.
  always_comb begin
    Inst_Req_Valid = 1'b0;
    Inst_Ready     = 1'b0;
    ALUop          = OP_ADD;
    ALUSrcA        = 2'b00;
    ALUSrcB        = 2'b00;
    PCWrite        = 1'b0;
    PCSrc          = 2'b00;
    ALUOutWrite    = 1'b0;
    RF_wen         = 1'b0;
    RF_waddr       = 5'd0;
    MemtoReg       = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    if (rst) begin
      ALUop = 3'b000;
    end else begin
      case (state)
        S_IF: begin
          Inst_Req_Valid = 1'b1;
          ALUSrcB        = 2'b01;
          PCWrite        = Inst_Req_Ready;
        end
        S_IW: Inst_Ready = 1'b1;
        S_ID: begin
          ALUSrcB     = 2'b10;
          ALUOutWrite = 1'b1;
        end
        S_EX: begin
          ALUSrcA = 2'b01;
          if (is_addu)       ALUop = OP_ADD;
          else if (is_subu)  ALUop = OP_SUB;
          else if (is_and)   ALUop = OP_AND;
          else if (is_or)    ALUop = OP_OR;
          else if (is_slt)   ALUop = OP_SLT;
          else if (is_sltu)  ALUop = OP_SLTU;
          else if (is_sll) begin
            ALUSrcA = 2'b10;
            ALUop   = OP_SLL;
          end else if (is_addiu | is_slti | is_sltiu) begin
            ALUSrcB = 2'b10;
            ALUop   = is_addiu ? OP_ADD : (is_slti ? OP_SLT : OP_SLTU);
          end else if (is_lui) begin
            ALUSrcB = 2'b11;
            ALUop   = OP_LUI;
          end else if (is_lw | is_sw) begin
            ALUSrcB     = 2'b10;
            ALUOutWrite = 1'b1;
          end else if (is_beq | is_bne) begin
            ALUop   = OP_SUB;
            PCSrc   = 2'b01;
            PCWrite = is_beq ? Zero : ~Zero;
          end else if (is_j) begin
            PCWrite = 1'b1;
            PCSrc   = 2'b10;
          end else if (is_jr) begin
            PCWrite = 1'b1;
            PCSrc   = 2'b11;
          end
        end
        S_ST: MemWrite = 1'b1;
        S_LD: MemRead  = 1'b1;
        S_RDW: begin
          RF_wen   = Read_data_Valid;
          MemtoReg = Read_data_Valid;
          RF_waddr = ir[20:16];
        end
        S_WB: begin
          RF_wen   = 1'b1;
          RF_waddr = r_type ? ir[15:11] : ir[20:16];
        end
        default: ;
      endcase
    end
  end

  assign IR = rst ? 32'd0 : ir;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] inst_q;
  logic        retire;

  // Leaving any post-fetch state for IF marks one completed instruction (nops leave from ID).
  assign retire = (state != S_IF) && (next_state == S_IF);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= 32'd0;
      inst_q  <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) inst_q <= inst_q + 32'd1;
    end
  end

  assign Cycle_cnt = rst ? 32'd0 : cycle_q;
  assign Inst_cnt  = rst ? 32'd0 : inst_q;
`else
  assign Cycle_cnt = 32'd0;
  assign Inst_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: steps instructions cycle by cycle and checks the decoded controls.
module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instruction;
  logic        Inst_Req_Valid, Inst_Req_Ready, Inst_Valid, Inst_Ready, Zero;
  logic [2:0]  ALUop;
  logic [1:0]  ALUSrcA, ALUSrcB, PCSrc;
  logic        PCWrite, ALUOutWrite, RF_wen, MemtoReg, MemRead, MemWrite;
  logic [4:0]  RF_waddr;
  logic        Mem_Req_Ready, Read_data_Valid;
  logic [31:0] IR, Cycle_cnt, Inst_cnt;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [31:0] ADDU = 32'h00432021;
  localparam logic [31:0] SW   = 32'hAC430008;
  localparam logic [31:0] J    = 32'h08000100;
  localparam logic [31:0] NOPX = 32'hFC000000;
  localparam logic [31:0] LW   = 32'h8C450004;
  localparam logic [31:0] BEQ  = 32'h10220003;
  localparam logic [31:0] SLL  = 32'h00031100;
  localparam logic [31:0] LUI  = 32'h3C051234;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .Instruction(Instruction),
    .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Zero(Zero),
    .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUOutWrite(ALUOutWrite),
    .RF_wen(RF_wen), .RF_waddr(RF_waddr), .MemtoReg(MemtoReg),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem_Req_Ready(Mem_Req_Ready), .Read_data_Valid(Read_data_Valid),
    .IR(IR), .Cycle_cnt(Cycle_cnt), .Inst_cnt(Inst_cnt)
  );

  function automatic logic [31:0] ctrlWord();
    return {10'd0, Inst_Req_Valid, Inst_Ready, PCWrite, ALUOutWrite, RF_wen, MemtoReg,
            MemRead, MemWrite, ALUop, ALUSrcA, ALUSrcB, PCSrc, RF_waddr};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic irr, input logic iv, input logic mrr, input logic rdv, input logic z);
    Inst_Req_Ready  = irr;
    Inst_Valid      = iv;
    Mem_Req_Ready   = mrr;
    Read_data_Valid = rdv;
    Zero            = z;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // IF and IW with readies high; returns positioned in ID.
  task automatic fetch(input logic [31:0] instr);
    Instruction = instr;
    checkOutput("if_req_valid", {31'd0, Inst_Req_Valid}, 32'd1);
    checkOutput("if_pcwrite", {31'd0, PCWrite}, 32'd1);
    checkOutput("if_alu_pc4", {27'd0, ALUop, ALUSrcB}, {27'd0, 3'b010, 2'b01});
    nextCycle();
    checkOutput("iw_inst_ready", {31'd0, Inst_Ready}, 32'd1);
    nextCycle();
  endtask

  initial begin
    rst = 1'b1;
    Instruction = 32'd0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("rst_ctrl_zero", ctrlWord(), 32'd0);
    checkOutput("rst_ir_zero", IR, 32'd0);
    rst = 1'b0;
    #1;

    // addu $4,$2,$3
    fetch(ADDU);
    checkOutput("addu_id_aluoutw", {31'd0, ALUOutWrite}, 32'd1);
    checkOutput("addu_id_no_wen", {31'd0, RF_wen}, 32'd0);
    nextCycle();
    checkOutput("addu_ex_alu", {25'd0, ALUop, ALUSrcA, ALUSrcB}, {25'd0, 3'b010, 2'b01, 2'b00});
    checkOutput("addu_ex_no_wen", {31'd0, RF_wen}, 32'd0);
    nextCycle();
    checkOutput("addu_wb_wen", {31'd0, RF_wen}, 32'd1);
    checkOutput("addu_wb_waddr", {27'd0, RF_waddr}, 32'd4);
    checkOutput("addu_wb_memtoreg", {31'd0, MemtoReg}, 32'd0);
    checkOutput("addu_ir", IR, ADDU);
    nextCycle();

    // sw $3,8($2)
    fetch(SW);
    nextCycle();
    checkOutput("sw_ex_ctrl", {27'd0, ALUOutWrite, ALUSrcA, ALUSrcB}, {27'd0, 1'b1, 2'b01, 2'b10});
    nextCycle();
    checkOutput("sw_st_memwrite", {31'd0, MemWrite}, 32'd1);
    checkOutput("sw_st_no_wen", {31'd0, RF_wen}, 32'd0);
    nextCycle();

    // j 0x100
    fetch(J);
    nextCycle();
    checkOutput("j_ex_pc", {29'd0, PCWrite, PCSrc}, {29'd0, 1'b1, 2'b10});
    nextCycle();
    checkOutput("j_back_in_if", {31'd0, Inst_Req_Valid}, 32'd1);
    checkOutput("perf_cycle_cnt", Cycle_cnt, PERF ? 32'd14 : 32'd0);
    checkOutput("perf_inst_cnt", Inst_cnt, PERF ? 32'd3 : 32'd0);

    // unknown opcode behaves as a nop and retires from ID
    fetch(NOPX);
    checkOutput("nop_id_aluoutw", {31'd0, ALUOutWrite}, 32'd1);
    nextCycle();
    checkOutput("nop_back_in_if", {31'd0, Inst_Req_Valid}, 32'd1);
    checkOutput("nop_inst_cnt", Inst_cnt, PERF ? 32'd4 : 32'd0);
    checkOutput("nop_cycle_cnt", Cycle_cnt, PERF ? 32'd17 : 32'd0);

    // lw $5,4($2) with stalled fetch, late instruction, stalled memory and late read data
    Instruction = 32'hFFFFFFFF;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("lw_if_stall_req", {31'd0, Inst_Req_Valid}, 32'd1);
    checkOutput("lw_if_stall_pcw", {31'd0, PCWrite}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("lw_if_pcw", {31'd0, PCWrite}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("lw_iw1_ready", {31'd0, Inst_Ready}, 32'd1);
    checkOutput("lw_iw1_ir_kept", IR, NOPX);
    nextCycle();
    checkOutput("lw_iw2_ready", {31'd0, Inst_Ready}, 32'd1);
    Instruction = LW;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("lw_id_ir", IR, LW);
    nextCycle();
    checkOutput("lw_ex_ctrl", {27'd0, ALUOutWrite, ALUSrcA, ALUSrcB}, {27'd0, 1'b1, 2'b01, 2'b10});
    nextCycle();
    checkOutput("lw_ld1_memread", {31'd0, MemRead}, 32'd1);
    nextCycle();
    checkOutput("lw_ld2_memread", {31'd0, MemRead}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("lw_ld3_memread", {31'd0, MemRead}, 32'd1);
    nextCycle();
    for (int k = 1; k <= 3; k++) begin
      checkOutput($sformatf("lw_rdw%0d_wait", k), {29'd0, MemRead, RF_wen, MemtoReg}, 32'd0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("lw_rdw4_write", {25'd0, RF_wen, MemtoReg, RF_waddr}, {25'd0, 1'b1, 1'b1, 5'd5});
    nextCycle();
    checkOutput("lw_back_in_if", {30'd0, Inst_Req_Valid, RF_wen}, {30'd0, 1'b1, 1'b0});

    // beq taken then not taken
    fetch(BEQ);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("beq_taken_ex", {26'd0, ALUop, PCWrite, PCSrc}, {26'd0, 3'b110, 1'b1, 2'b01});
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("beq_taken_if", {31'd0, Inst_Req_Valid}, 32'd1);
    fetch(BEQ);
    nextCycle();
    checkOutput("beq_not_taken_ex", {28'd0, ALUop, PCWrite}, {28'd0, 3'b110, 1'b0});
    nextCycle();
    checkOutput("beq_not_taken_if", {31'd0, Inst_Req_Valid}, 32'd1);

    // sll $2,$3,4
    fetch(SLL);
    nextCycle();
    checkOutput("sll_ex", {25'd0, ALUop, ALUSrcA, ALUSrcB}, {25'd0, 3'b100, 2'b10, 2'b00});
    nextCycle();
    checkOutput("sll_wb", {26'd0, RF_wen, RF_waddr}, {26'd0, 1'b1, 5'd2});
    nextCycle();

    // lui $5,0x1234
    fetch(LUI);
    nextCycle();
    checkOutput("lui_ex", {27'd0, ALUop, ALUSrcB}, {27'd0, 3'b101, 2'b11});
    nextCycle();
    checkOutput("lui_wb", {26'd0, RF_wen, RF_waddr}, {26'd0, 1'b1, 5'd5});
    nextCycle();

    // reset asserted mid-load aborts it
    fetch(LW);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("rstld_memread", {31'd0, MemRead}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstld_ctrl_zero", ctrlWord(), 32'd0);
    checkOutput("rstld_ir_zero", IR, 32'd0);
    checkOutput("rstld_cnt_zero", Cycle_cnt | Inst_cnt, 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rstld_in_if", {30'd0, Inst_Req_Valid, MemRead}, {30'd0, 1'b1, 1'b0});
    checkOutput("rstld_ir_reg", IR, 32'd0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rstld_no_wen%0d", k), {30'd0, RF_wen, Inst_Req_Valid}, {30'd0, 1'b0, 1'b1});
      nextCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
